regfile_dump_reader: RTL and testbench

//  Read-side sequencer for the 32x64 register file: on a start pulse it walks an

---
 rtl/regfile_dump_reader_pkg.sv | 20 ++
 rtl/regfile_dump_reader_if.sv | 30 +++
 rtl/regfile_dump_buffer.sv | 65 ++++++
 rtl/regfile_dump_reader.sv | 146 ++++++++++++++
 tb/tb_regfile_dump_reader.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_dump_reader_pkg.sv
// Shared constants for the register file dump reader: default widths (kept in
// step with the register file itself), FSM state codes and the beat record.
package regfile_dump_reader_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 2 ** ADDR_WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // One streamed register value together with its index and end-of-dump flag.
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] index;
    logic                  last;
  } beat_t;

endpackage

// File: rtl/regfile_dump_reader_if.sv
// Valid/ready stream carrying register values out of the dump reader.
// The master presents beats, the slave answers with out_ready.
interface regfile_dump_reader_if #(
  parameter int DATA_WIDTH = regfile_dump_reader_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_dump_reader_pkg::ADDR_WIDTH
);

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH-1:0] out_index;
  logic                  out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_index,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/regfile_dump_buffer.sv
// Two-entry slot buffer between the register file read ports and the output
// stream. A load replaces the whole contents (the caller only loads when the
// buffer is empty or its single remaining entry leaves in the same cycle);
// a pop shifts slot1 down into slot0. The head is always slot0.
module regfile_dump_buffer #(
  parameter int DATA_WIDTH = regfile_dump_reader_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_dump_reader_pkg::ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  load,
  input  logic                  load_two,
  input  logic [DATA_WIDTH-1:0] data0,
  input  logic [ADDR_WIDTH-1:0] index0,
  input  logic                  last0,
  input  logic [DATA_WIDTH-1:0] data1,
  input  logic [ADDR_WIDTH-1:0] index1,
  input  logic                  last1,
  input  logic                  pop,
  output logic [1:0]            count,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [ADDR_WIDTH-1:0] head_index,
  output logic                  head_last
);
  import regfile_dump_reader_pkg::*;

  logic [DATA_WIDTH-1:0] slot0_data;
  logic [ADDR_WIDTH-1:0] slot0_index;
  logic                  slot0_last;
  logic [DATA_WIDTH-1:0] slot1_data;
  logic [ADDR_WIDTH-1:0] slot1_index;
  logic                  slot1_last;

  // Slot storage and occupancy: clear beats load, load beats pop.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      slot0_data  <= '0;
      slot0_index <= '0;
      slot0_last  <= 1'b0;
      slot1_data  <= '0;
      slot1_index <= '0;
      slot1_last  <= 1'b0;
      count       <= 2'd0;
    end else if (load) begin
      slot0_data  <= data0;
      slot0_index <= index0;
      slot0_last  <= last0;
      slot1_data  <= data1;
      slot1_index <= index1;
      slot1_last  <= last1;
      count       <= load_two ? 2'd2 : 2'd1;
    end else if (pop && (count != 2'd0)) begin
      slot0_data  <= slot1_data;
      slot0_index <= slot1_index;
      slot0_last  <= slot1_last;
      count       <= count - 2'd1;
    end
  end

  assign head_data  = slot0_data;
  assign head_index = slot0_index;
  assign head_last  = slot0_last;

endmodule

// File: rtl/regfile_dump_reader.sv
// Read-side sequencer for the register file: walks an inclusive register range
// two registers per fetch using both read ports, parks each pair in a 2-entry
// buffer and streams the values out one beat per cycle over valid/ready.
module regfile_dump_reader #(
  parameter int DATA_WIDTH = regfile_dump_reader_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_dump_reader_pkg::ADDR_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [ADDR_WIDTH-1:0]  first_reg,
  input  logic [ADDR_WIDTH-1:0]  last_reg,
  input  logic                   abort,
  output logic [ADDR_WIDTH-1:0]  select_a,
  output logic [ADDR_WIDTH-1:0]  select_b,
  input  logic [DATA_WIDTH-1:0]  out_a,
  input  logic [DATA_WIDTH-1:0]  out_b,
  regfile_dump_reader_if.master  stream,
  output logic                   busy,
  output logic                   done,
  output logic                   range_err
);
  import regfile_dump_reader_pkg::*;

  // One extra bit so stepping the pointer by two past the top register can
  // never wrap around onto a low index.
  localparam int                   PTR_WIDTH = ADDR_WIDTH + 1;
  localparam logic [PTR_WIDTH-1:0] PTR_ONE   = PTR_WIDTH'(1);
  localparam logic [PTR_WIDTH-1:0] PTR_TWO   = PTR_WIDTH'(2);

  logic [1:0]            state;
  logic [PTR_WIDTH-1:0]  ptr;
  logic [PTR_WIDTH-1:0]  last_q;
  logic                  done_q;
  logic                  range_err_q;

  logic [1:0]            count;
  logic [DATA_WIDTH-1:0] head_data;
  logic [ADDR_WIDTH-1:0] head_index;
  logic                  head_last;

  logic                  fire;
  logic                  capture;
  logic                  final_pair;
  logic                  load_two;
  logic [ADDR_WIDTH-1:0] index0;
  logic [ADDR_WIDTH-1:0] index1;
  logic                  last0;
  logic                  last1;
  logic                  in_fetch;

  assign in_fetch   = (state == ST_FETCH);
  assign fire       = stream.out_valid & stream.out_ready;
  assign index0     = ptr[ADDR_WIDTH-1:0];
  assign index1     = ptr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(1);
  assign last0      = (ptr == last_q);
  assign last1      = ((ptr + PTR_ONE) == last_q);
  assign load_two   = (ptr != last_q);
  assign final_pair = last0 | last1;
  assign capture    = in_fetch && ((count == 2'd0) || ((count == 2'd1) && fire));

  assign select_a   = in_fetch ? index0 : '0;
  assign select_b   = in_fetch ? index1 : '0;

  regfile_dump_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_buffer (
    .clock      (clock),
    .reset      (reset),
    .clear      (abort),
    .load       (capture),
    .load_two   (load_two),
    .data0      (out_a),
    .index0     (index0),
    .last0      (last0),
    .data1      (out_b),
    .index1     (index1),
    .last1      (last1),
    .pop        (fire),
    .count      (count),
    .head_data  (head_data),
    .head_index (head_index),
    .head_last  (head_last)
  );

  assign stream.out_valid = (count != 2'd0);
  assign stream.out_data  = head_data;
  assign stream.out_index = head_index;
  assign stream.out_last  = head_last;

  assign busy      = (state != ST_IDLE);
  assign done      = done_q;
  assign range_err = range_err_q;

  // Dump sequencing: accept a range, fetch pairs until the final one is
  // buffered, then drain until the last beat leaves; abort cancels silently.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      last_q      <= '0;
      done_q      <= 1'b0;
      range_err_q <= 1'b0;
    end else if (abort) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      done_q      <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      range_err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (first_reg <= last_reg) begin
              state  <= ST_FETCH;
              ptr    <= {1'b0, first_reg};
              last_q <= {1'b0, last_reg};
            end else begin
              range_err_q <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (capture) begin
            ptr <= ptr + PTR_TWO;
            if (final_pair) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (fire && head_last) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for the register file dump reader: a behavioural register file feeds
// the read ports, each dump request queues the beats the range should produce,
// and an independent monitor compares every presented beat and the done pulse.
module tb_regfile_dump_reader;
  import regfile_dump_reader_pkg::*;

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  start;
  logic                  abort;
  logic [ADDR_WIDTH-1:0] first_reg;
  logic [ADDR_WIDTH-1:0] last_reg;
  logic [ADDR_WIDTH-1:0] select_a;
  logic [ADDR_WIDTH-1:0] select_b;
  logic [DATA_WIDTH-1:0] out_a;
  logic [DATA_WIDTH-1:0] out_b;
  logic                  busy;
  logic                  done;
  logic                  range_err;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  beat_t exp_q [$];
  int    compared   = 0;
  int    mismatched = 0;
  logic  done_exp   = 1'b0;
  int    ready_mode = 0;
  int    pat_idx    = 0;
  logic [3:0] ready_pat = 4'b1001;

  regfile_dump_reader_if stream ();

  regfile_dump_reader dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .first_reg (first_reg),
    .last_reg  (last_reg),
    .abort     (abort),
    .select_a  (select_a),
    .select_b  (select_b),
    .out_a     (out_a),
    .out_b     (out_b),
    .stream    (stream),
    .busy      (busy),
    .done      (done),
    .range_err (range_err)
  );

  assign out_a = regs[select_a];
  assign out_b = regs[select_b];

  always #5 clock = ~clock;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic fail_now(input string name, input string msg);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: %s at %0t", name, msg, $time);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic queue_range(input int first_i, input int last_i);
    beat_t b;
    for (int i = first_i; i <= last_i; i++) begin
      b.data  = regs[i];
      b.index = ADDR_WIDTH'(i);
      b.last  = (i == last_i);
      exp_q.push_back(b);
    end
  endtask

  task automatic apply_stimulus(input int first_i, input int last_i);
    step();
    start     = 1'b1;
    first_reg = ADDR_WIDTH'(first_i);
    last_reg  = ADDR_WIDTH'(last_i);
    step();
    start     = 1'b0;
  endtask

  // Full dump: queue expectations, start, wait (bounded) for done, report the
  // number of cycles from the start cycle to the cycle showing done.
  task automatic run_dump(input int first_i, input int last_i, output int cycles);
    queue_range(first_i, last_i);
    apply_stimulus(first_i, last_i);
    cycles = 1;
    while (cycles < 3000) begin
      @(negedge clock);
      if (done === 1'b1) break;
      cycles++;
    end
    if (cycles >= 3000) begin
      fail_now("done_timeout", $sformatf("range %0d..%0d never finished", first_i, last_i));
      exp_q.delete();
    end else begin
      check_output("queue_drained", 64'(exp_q.size()), 64'd0);
      check_output("busy_after_done", 64'(busy), 64'd0);
    end
  endtask

  task automatic wait_beat(input int index, output bit found);
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      if (stream.out_valid === 1'b1 && stream.out_index == ADDR_WIDTH'(index)) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) fail_now("beat_wait_timeout", $sformatf("beat %0d never presented", index));
  endtask

  task automatic check_reset_values();
    @(negedge clock);
    check_output("rst_select_a", 64'(select_a), 64'd0);
    check_output("rst_select_b", 64'(select_b), 64'd0);
    check_output("rst_out_valid", 64'(stream.out_valid), 64'd0);
    check_output("rst_out_last", 64'(stream.out_last), 64'd0);
    check_output("rst_out_data", stream.out_data, 64'd0);
    check_output("rst_out_index", 64'(stream.out_index), 64'd0);
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_range_err", 64'(range_err), 64'd0);
  endtask

  // Consumer side: out_ready pattern selected by ready_mode, updated after each edge.
  always @(posedge clock) begin
    #1;
    case (ready_mode)
      0: stream.out_ready = 1'b1;
      1: begin
        stream.out_ready = ready_pat[pat_idx];
        pat_idx = (pat_idx + 1) % 4;
      end
      2: stream.out_ready = 1'($urandom_range(0, 1));
      default: stream.out_ready = 1'b0;
    endcase
  end

  // Scoreboard monitor: every presented beat must match the queue head; a
  // fired last beat means done is due on the following cycle.
  always @(negedge clock) begin
    check_output("done", 64'(done), 64'(done_exp));
    done_exp = 1'b0;
    if (stream.out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_beat", $sformatf("index %0d data %0h", stream.out_index, stream.out_data));
      end else begin
        check_output("out_data", stream.out_data, exp_q[0].data);
        check_output("out_index", 64'(stream.out_index), 64'(exp_q[0].index));
        check_output("out_last", 64'(stream.out_last), 64'(exp_q[0].last));
        if (stream.out_ready === 1'b1) begin
          done_exp = exp_q[0].last;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int   cyc;
    bit   found;
    int   f;
    int   l;
    reset            = 1'b1;
    start            = 1'b0;
    abort            = 1'b0;
    first_reg        = '0;
    last_reg         = '0;
    stream.out_ready = 1'b0;
    for (int n = 0; n < NUM_REGS; n++) begin
      regs[n] = {32'hA5A5_0000 + 32'(n), 32'(n)};
    end

    repeat (2) @(posedge clock);
    check_reset_values();
    step();
    reset = 1'b0;

    $display("[TB] full range 0..31 with consumer always ready");
    ready_mode = 0;
    run_dump(0, 31, cyc);
    check_output("full_range_cycles", 64'(cyc), 64'd34);

    $display("[TB] single register 5..5");
    run_dump(5, 5, cyc);
    check_output("single_cycles", 64'(cyc), 64'd3);

    $display("[TB] range 3..8 with ready pattern 1,0,0,1");
    ready_mode = 1;
    pat_idx    = 0;
    run_dump(3, 8, cyc);
    ready_mode = 0;

    $display("[TB] inverted range 9..4");
    apply_stimulus(9, 4);
    @(negedge clock);
    check_output("range_err_pulse", 64'(range_err), 64'd1);
    check_output("range_err_busy", 64'(busy), 64'd0);
    @(negedge clock);
    check_output("range_err_cleared", 64'(range_err), 64'd0);
    check_output("range_err_idle", 64'(busy), 64'd0);

    $display("[TB] abort at fourth beat, then 10..11");
    queue_range(0, 31);
    apply_stimulus(0, 31);
    wait_beat(3, found);
    abort = 1'b1;
    step();
    abort = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check_output("abort_valid", 64'(stream.out_valid), 64'd0);
    check_output("abort_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clock);
    run_dump(10, 11, cyc);
    check_output("after_abort_cycles", 64'(cyc), 64'd4);

    $display("[TB] reset with beat 7 pending, then 2..3");
    queue_range(0, 31);
    apply_stimulus(0, 31);
    wait_beat(6, found);
    ready_mode = 3;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    ready_mode = 0;
    check_reset_values();
    run_dump(2, 3, cyc);
    check_output("after_reset_cycles", 64'(cyc), 64'd4);

    $display("[TB] randomized ranges and register contents");
    for (int it = 0; it < 10; it++) begin
      for (int n = 0; n < NUM_REGS; n++) begin
        regs[n] = {$urandom, $urandom};
      end
      f = $urandom_range(0, 31);
      l = $urandom_range(f, 31);
      ready_mode = (it % 2 == 0) ? 0 : 2;
      run_dump(f, l, cyc);
      if (ready_mode == 0) begin
        check_output("random_cycles", 64'(cyc), 64'(2 + l - f + 1));
      end
    end
    ready_mode = 0;
    repeat (3) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
